// File: rtl/drop_grid_engine.sv
// drop_grid_engine: two-player drop-piece game with falling animation, win/draw detection and 16x16 red/green rendering
module drop_grid_engine #(
   parameter int COLS      = 4,
   parameter int ROWS      = 5,
   parameter int CELL_W    = 2,
   parameter int CELL_H    = 3,
   parameter int TICK_DIV  = 2,
   parameter int WIN_LEN   = 4,
   parameter int ALT_TURNS = 1
) (
   input  logic                    clk,
   input  logic                    RST,
   input  logic                    drop_req,
   input  logic [$clog2(COLS)-1:0] drop_col,
   input  logic                    drop_player,
   output logic                    busy,
   output logic                    rejected,
   output logic                    landed,
   output logic                    turn,
   output logic [1:0]              winner,
   output logic                    game_over,
   output logic [15:0][15:0]       RedPixels,
   output logic [15:0][15:0]       GrnPixels
);
   localparam int CW     = $clog2(COLS);
   localparam int RW     = $clog2(ROWS);
   localparam int TW     = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   localparam int PITCH  = CELL_W + 1;
   localparam int GRID_X = COLS * PITCH;
   localparam int GRID_Y = ROWS * CELL_H;

   typedef enum logic [1:0] {IDLE, FALL, LAND, CHECK} state_t;

   state_t          state, state_n;
   logic [COLS-1:0] occ [ROWS];
   logic [COLS-1:0] ply [ROWS];
   logic [COLS-1:0] mine [ROWS];
   logic [RW-1:0]   row;
   logic [CW-1:0]   col;
   logic            player;
   logic [TW-1:0]   tick;
   logic            can_drop, accept, refuse, wrap, below_free, falling, win;
   logic [ROWS*COLS*4-1:0] lines;
   logic [15:0][15:0] grid, red_n, grn_n;

   assign can_drop   = !game_over && int'(drop_col) < COLS && !occ[0][drop_col];
   assign wrap       = tick == TW'(TICK_DIV - 1);
   assign below_free = int'(row) + 1 < ROWS && !occ[row + RW'(1)][col];
   assign falling    = state == FALL || state == LAND;
   assign win        = |lines;

   // State register; reset also discards any falling piece
   always_ff @(posedge clk) begin
      state <= RST ? IDLE : state_n;
   end

   // Next state plus the accept/refuse strobes taken from IDLE
   always_comb begin
      state_n = state;
      accept  = 1'b0;
      refuse  = 1'b0;
      case (state)
         IDLE: begin
            accept  = drop_req && can_drop;
            refuse  = drop_req && !can_drop;
            state_n = accept ? FALL : IDLE;
         end
         FALL:    state_n = wrap && !below_free ? LAND : FALL;
         LAND:    state_n = CHECK;
         default: state_n = IDLE;
      endcase
   end

   // Falling piece, board contents, turn and game status
   always_ff @(posedge clk) begin
      if (RST) begin
         occ       <= '{default: '0};
         ply       <= '{default: '0};
         row       <= '0;
         col       <= '0;
         player    <= 1'b0;
         tick      <= '0;
         busy      <= 1'b0;
         rejected  <= 1'b0;
         landed    <= 1'b0;
         turn      <= 1'b0;
         winner    <= 2'b00;
         game_over <= 1'b0;
      end else begin
         busy     <= accept ? 1'b1 : (state == LAND ? 1'b0 : busy);
         rejected <= refuse;
         landed   <= state == LAND;
         if (accept) begin
            col    <= drop_col;
            player <= ALT_TURNS != 0 ? turn : drop_player;
            row    <= '0;
            tick   <= '0;
         end
         if (state == FALL) begin
            tick <= wrap ? '0 : tick + TW'(1);
            if (wrap && below_free) row <= row + RW'(1);
         end
         if (state == LAND) begin
            occ[row][col] <= 1'b1;
            ply[row][col] <= player;
            if (ALT_TURNS != 0) turn <= !turn;
         end
         if (state == CHECK) begin
            if (win) begin
               winner    <= player ? 2'b10 : 2'b01;
               game_over <= 1'b1;
            end else if (&occ[0]) begin
               game_over <= 1'b1;
            end
         end
      end
   end

   // Every line of WIN_LEN cells that fits on the board, from each start cell in four directions
   for (genvar r = 0; r < ROWS; r++) begin : g_r
      assign mine[r] = occ[r] & (player ? ply[r] : ~ply[r]);
      for (genvar c = 0; c < COLS; c++) begin : g_c
         for (genvar d = 0; d < 4; d++) begin : g_d
            localparam int DR = d == 0 ? 0 : 1;
            localparam int DC = d == 1 ? 0 : (d == 3 ? -1 : 1);
            localparam int ER = r + (WIN_LEN - 1) * DR;
            localparam int EC = c + (WIN_LEN - 1) * DC;
            if (ER < ROWS && EC >= 0 && EC < COLS) begin : g_fit
               logic [WIN_LEN-1:0] bits;
               for (genvar k = 0; k < WIN_LEN; k++) begin : g_k
                  assign bits[k] = mine[r + k * DR][c + k * DC];
               end
               assign lines[(r * COLS + c) * 4 + d] = &bits;
            end else begin : g_none
               assign lines[(r * COLS + c) * 4 + d] = 1'b0;
            end
         end
      end
   end

   // Per-pixel mapping: grid lines in both colours, cells coloured by owner or by the falling piece
   for (genvar y = 0; y < 16; y++) begin : g_y
      for (genvar x = 0; x < 16; x++) begin : g_x
         localparam bit ON_GRID = y <= GRID_Y && x <= GRID_X && (x % PITCH == 0 || y == GRID_Y);
         localparam bit IN_CELL = y < GRID_Y && x < GRID_X && x % PITCH != 0;
         assign grid[y][x] = ON_GRID;
         if (IN_CELL) begin : g_cell
            localparam int R = y / CELL_H;
            localparam int C = x / PITCH;
            logic here;
            assign here        = falling && row == RW'(R) && col == CW'(C);
            assign red_n[y][x] = (occ[R][C] && !ply[R][C]) || (here && !player);
            assign grn_n[y][x] = (occ[R][C] && ply[R][C]) || (here && player);
         end else begin : g_other
            assign red_n[y][x] = ON_GRID;
            assign grn_n[y][x] = ON_GRID;
         end
      end
   end

   // Pixel arrays refresh every cycle; reset shows the bare grid straight away
   always_ff @(posedge clk) begin
      RedPixels <= RST ? grid : red_n;
      GrnPixels <= RST ? grid : grn_n;
   end
endmodule

// File: doc/drop_grid_engine.md
Name: drop_grid_engine

Overview:
- Parametrised drop-piece game engine for the 16x16 red/green LED matrix.
- Holds a ROWS x COLS board with two players: player 0 is red, player 1 is green.
- Animates a dropped piece falling one cell per tick, detects WIN_LEN-in-a-row and draw, and renders board, falling piece and an orange grid into the pixel arrays.
- Sits between the debounced key/column-select logic and the LED driver.

Parameters:
- COLS, 4, number of board columns (2..5).
- ROWS, 5, number of board rows (2..5).
- CELL_W, 2, cell width in pixels; column pitch = CELL_W+1.
- CELL_H, 3, cell height in pixels.
- TICK_DIV, 2, clock cycles per fall step (>=1).
- WIN_LEN, 4, pieces in a line needed to win (2..max(ROWS,COLS)).
- ALT_TURNS, 1, 1 = engine alternates players; 0 = player taken from drop_player.
- Legality constraints: COLS*(CELL_W+1)+1 <= 16 and ROWS*CELL_H+1 <= 16.

Ports:
- clk  in  1  clock
- RST  in  1  reset, synchronous, active-high
- drop_req  in  1  request to drop a piece; sampled every cycle
- drop_col  in  $clog2(COLS)  target column, 0 = leftmost
- drop_player  in  1  player for the drop; used only when ALT_TURNS=0
- busy  out  1  a piece is falling
- rejected  out  1  one-cycle pulse: request refused
- landed  out  1  one-cycle pulse: piece written to board
- turn  out  1  next player when ALT_TURNS=1
- winner  out  2  00 none/draw, 01 red, 10 green
- game_over  out  1  win or board full
- RedPixels  out  16x16  red LED array, [row][col]
- GrnPixels  out  16x16  green LED array, [row][col]

Behaviour:
- Reset values: board empty; FSM in IDLE; busy=0, rejected=0, landed=0, turn=0, winner=00, game_over=0; tick counter=0.
- RST mid-fall: the falling piece is discarded.
- FSM states:
  - IDLE:
    - drop_req=1 with game_over=0, drop_col<COLS and cell (row 0, drop_col) empty: accept. Latch column and player, piece row=0, tick counter=0, go to FALL. busy=1 from the next cycle.
    - drop_req=1 otherwise: rejected pulses for 1 cycle; state is unchanged.
  - FALL: tick counter counts 0..TICK_DIV-1. On the cycle it wraps:
    - Cell below is inside the board and empty: piece row increments.
    - Otherwise: go to LAND.
    - drop_req in FALL is ignored, with no rejected pulse.
  - LAND (1 cycle):
    - Write the player into board(row,col).
    - Pulse landed; busy=0 next cycle.
    - If ALT_TURNS=1, toggle turn.
    - Go to CHECK.
  - CHECK (1 cycle):
    - Scan horizontal, vertical and both diagonals for WIN_LEN consecutive cells of the landed player.
    - Win: winner = landed player (01 red, 10 green), game_over=1.
    - No win and all top-row cells occupied: winner=00, game_over=1.
    - Return to IDLE.
- Request timing: a request sampled in LAND or CHECK is ignored. The earliest next accept is the first IDLE cycle.
- Latency for a drop onto an empty column: landed goes high (ROWS*TICK_DIV)+1 cycles after the accepting edge.
- game_over holds until RST. All later requests are rejected.
- Rendering, registered and updated every cycle:
  - Grid lines, lit in both colours: pixel columns x = k*(CELL_W+1) for k=0..COLS, over rows 0..ROWS*CELL_H. Also pixel row ROWS*CELL_H, over columns 0..COLS*(CELL_W+1).
  - Cell (r,c) fills pixel rows r*CELL_H .. r*CELL_H+CELL_H-1 and columns c*(CELL_W+1)+1 .. c*(CELL_W+1)+CELL_W.
    - Red if player 0, green if player 1.
    - The falling piece is drawn the same way at its current row.
  - All other pixels are 0.
  - With defaults, after reset every row 0..14 = 0x1249 in both colours, and row 15 = 0x1FFF in both.

Test Plan:
- Reset then idle -> RedPixels[0]=GrnPixels[0]=0x1249, RedPixels[15]=0x1FFF, busy=0, winner=00.
- Defaults, drop_col=0 on empty board -> piece steps rows 0..4 every 2 cycles. landed pulses 11 cycles after accept. RedPixels[12..14][2:1]=11. turn=1.
- Fill column 2 with 5 alternating drops, then a 6th drop to column 2 -> rejected pulse, busy stays 0, board unchanged.
- Red in columns 0,1,2,3 on the bottom row, interleaved with green drops elsewhere -> CHECK sets winner=01, game_over=1. A subsequent drop_req is rejected.
- RST asserted while a piece is at row 2 -> next cycle busy=0, the pixel arrays equal the reset pattern, and the board is empty.
- ALT_TURNS=0, drop_player=1 on two consecutive drops -> both pieces render green and turn stays 0. Also run COLS=5, CELL_W=2 to check grid line at pixel column 15.
